spart_rx: RTL and testbench

Receive half of the SPART serial port.
- Synchronises the asynchronous rxd line and oversamples it using the baud-generator enable tick.
- Frames 8N1 characters, LSB first, and holds each received byte in a one-deep buffer for the bus interface.
- Sits between the top-level rxd pin and the SPART bus-interface/driver logic, alongside the transmit path on txd.

---
 rtl/spart_pkg.sv | 19 +
 rtl/spart_sync.sv | 29 ++
 rtl/spart_rx.sv | 146 ++++++++++++++
 tb/tb_spart_rx.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/spart_pkg.sv
// spart_pkg: definitions shared by the SPART receive path, transmit path and
// baud generator.
//   - rx_state_t     : receive framing state machine encoding
//   - OVERSAMPLE_DEF : default enable ticks per bit period
//   - DATA_W_DEF     : default data bits per character
package spart_pkg;

    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_W_DEF     = 8;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

endpackage

// File: rtl/spart_sync.sv
// spart_sync: two-flop synchroniser for a single asynchronous input.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset; both flops load RST_VAL
//   d     : asynchronous input
//   q     : synchronised output, two clk cycles behind d
module spart_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            // NOTE: non-blocking assignments make both flops sample together,
            // so the chain is two stages deep and not collapsed into one.
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/spart_rx.sv
// spart_rx: receive half of the SPART serial port. Oversamples the rxd pin
// with the baud enable tick, frames 8N1 characters (LSB first) and holds the
// last byte in a one-deep buffer for the bus interface.
//   clk         : system clock
//   rst_n       : asynchronous active-low reset
//   enable      : baud tick, one-cycle pulse at OVERSAMPLE x baud rate
//   rxd         : asynchronous serial input, idles high
//   rda_clr     : bus read acknowledge, clears rda and overrun
//   rx_data     : last good received byte
//   rda         : receive data available
//   framing_err : stop bit sampled low on the last frame
//   overrun     : a good frame completed while rda was still set
module spart_rx
    import spart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DATA_W     = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              rxd,
    input  logic              rda_clr,
    output logic [DATA_W-1:0] rx_data,
    output logic              rda,
    output logic              framing_err,
    output logic              overrun
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_W + 1);

    localparam logic [TICK_W-1:0] HALF_TICK = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_W - 1);

    rx_state_t         state;
    logic [TICK_W-1:0] tick_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift;
    logic              rxd_s;

    // Reset to 1 so the line looks idle and no false start is seen at release.
    spart_sync #(.RST_VAL(1'b1)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rxd),
        .q     (rxd_s)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RX_IDLE;
            tick_cnt    <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            rx_data     <= '0;
            rda         <= 1'b0;
            framing_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            // NOTE: the acknowledge clear comes first; a frame completing in
            // the same cycle assigns rda later in this block, and the last
            // non-blocking assignment wins, so a new byte is never lost.
            if (rda_clr) begin
                rda     <= 1'b0;
                overrun <= 1'b0;
            end

            case (state)
                RX_IDLE: begin
                    if (enable && !rxd_s) begin
                        state    <= RX_START;
                        tick_cnt <= '0;
                    end
                end

                // Re-check the line half a bit in; a high here was a glitch.
                RX_START: begin
                    if (enable) begin
                        if (tick_cnt == HALF_TICK) begin
                            tick_cnt <= '0;
                            if (!rxd_s) begin
                                state   <= RX_DATA;
                                bit_cnt <= '0;
                            end else begin
                                state <= RX_IDLE;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end

                // Sampling a full bit period after the start mid-point keeps
                // every sample near the centre of its bit.
                RX_DATA: begin
                    if (enable) begin
                        if (tick_cnt == LAST_TICK) begin
                            tick_cnt <= '0;
                            shift    <= {rxd_s, shift[DATA_W-1:1]};
                            bit_cnt  <= bit_cnt + 1'b1;
                            if (bit_cnt == LAST_BIT) begin
                                state <= RX_STOP;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end

                RX_STOP: begin
                    if (enable) begin
                        if (tick_cnt == LAST_TICK) begin
                            tick_cnt <= '0;
                            if (rxd_s) begin
                                rx_data     <= shift;
                                rda         <= 1'b1;
                                framing_err <= 1'b0;
                                // An acknowledged old byte is not an overrun.
                                overrun     <= rda && !rda_clr;
                                state       <= RX_IDLE;
                            end else begin
                                framing_err <= 1'b1;
                                state       <= RX_BREAK;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end

                // Hold off until the line returns high so a break condition
                // does not retrigger a stream of bogus frames.
                RX_BREAK: begin
                    if (rxd_s) begin
                        state <= RX_IDLE;
                    end
                end

                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spart_rx.sv
// tb_spart_rx: directed bench for spart_rx. Inputs change 1 time unit after
// the rising clk edge; outputs are checked at that same point, away from the
// edge.
module tb_spart_rx;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       enable  = 1'b0;
    logic       rxd     = 1'b1;
    logic       rda_clr = 1'b0;
    logic [7:0] rx_data;
    logic       rda;
    logic       framing_err;
    logic       overrun;

    int tests   = 0;
    int fails   = 0;
    int ena_div = 1;
    int cyc_cnt = 0;

    spart_rx #(.OVERSAMPLE(16), .DATA_W(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .rxd         (rxd),
        .rda_clr     (rda_clr),
        .rx_data     (rx_data),
        .rda         (rda),
        .framing_err (framing_err),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // Advance n clocks; enable is high one cycle in every ena_div.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc_cnt++;
            enable = ((cyc_cnt % ena_div) == 0);
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Start bit plus data bits, LSB first; the caller drives the stop bit.
    task automatic send_head(input logic [7:0] d, input int bitlen);
        rxd = 1'b0;
        cyc(bitlen);
        for (int i = 0; i < 8; i++) begin
            rxd = d[i];
            cyc(bitlen);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input int bitlen);
        send_head(d, bitlen);
        rxd = 1'b1;
        cyc(bitlen);
    endtask

    task automatic pulse_clr();
        rda_clr = 1'b1;
        cyc(1);
        rda_clr = 1'b0;
    endtask

    initial begin
        // Reset state
        cyc(3);
        check("rst_rda", rda, 0);
        check("rst_data", rx_data, 8'h00);
        check("rst_ferr", framing_err, 0);
        check("rst_ovr", overrun, 0);
        rst_n = 1'b1;
        cyc(4);

        // 1. Good frame 0xA5; start edge at clk 0, stop sampled at edge 155
        send_head(8'hA5, 16);
        rxd = 1'b1;
        cyc(10);
        check("t1_rda_early", rda, 0);
        cyc(1);
        check("t1_rda", rda, 1);
        check("t1_data", rx_data, 8'hA5);
        check("t1_ferr", framing_err, 0);
        check("t1_ovr", overrun, 0);
        cyc(5);

        // 2. Glitch of 4 clks is rejected at the start mid-point
        rxd = 1'b0;
        cyc(4);
        rxd = 1'b1;
        cyc(30);
        check("t2_rda", rda, 1);
        check("t2_data", rx_data, 8'hA5);
        check("t2_ferr", framing_err, 0);
        check("t2_ovr", overrun, 0);
        pulse_clr();
        check("t2_clr_rda", rda, 0);

        // 3. Framing error: stop bit low for 32 clks, then a good 0x55
        send_head(8'h3C, 16);
        rxd = 1'b0;
        cyc(32);
        check("t3_ferr", framing_err, 1);
        check("t3_rda", rda, 0);
        check("t3_data", rx_data, 8'hA5);
        rxd = 1'b1;
        cyc(20);
        check("t3_ferr_hold", framing_err, 1);
        check("t3_rda_hold", rda, 0);
        send_frame(8'h55, 16);
        cyc(4);
        check("t3_good_data", rx_data, 8'h55);
        check("t3_good_rda", rda, 1);
        check("t3_good_ferr", framing_err, 0);

        // 4. Overrun: two frames without acknowledge
        pulse_clr();
        send_frame(8'h11, 16);
        check("t4_first_data", rx_data, 8'h11);
        check("t4_first_ovr", overrun, 0);
        send_frame(8'h22, 16);
        check("t4_data", rx_data, 8'h22);
        check("t4_rda", rda, 1);
        check("t4_ovr", overrun, 1);
        pulse_clr();
        check("t4_clr_rda", rda, 0);
        check("t4_clr_ovr", overrun, 0);
        check("t4_clr_data", rx_data, 8'h22);

        // 5. rda_clr in the exact completion cycle of 0x7E while rda=1
        send_frame(8'h99, 16);
        check("t5_pre_rda", rda, 1);
        check("t5_pre_data", rx_data, 8'h99);
        send_head(8'h7E, 16);
        rxd = 1'b1;
        cyc(10);
        rda_clr = 1'b1;
        cyc(1);
        rda_clr = 1'b0;
        check("t5_rda", rda, 1);
        check("t5_data", rx_data, 8'h7E);
        check("t5_ovr", overrun, 0);
        cyc(10);
        check("t5_rda_hold", rda, 1);

        // 6. Reset during data bit 3, then 0xC3 at 1-in-4 enable (64 clks/bit)
        rxd = 1'b0;
        cyc(16);
        rxd = 1'b1;
        cyc(16);
        rxd = 1'b0;
        cyc(16);
        rxd = 1'b1;
        cyc(16);
        rxd = 1'b0;
        cyc(8);
        rst_n = 1'b0;
        #1;
        check("t6_rst_rda", rda, 0);
        check("t6_rst_data", rx_data, 8'h00);
        check("t6_rst_ferr", framing_err, 0);
        check("t6_rst_ovr", overrun, 0);
        rxd = 1'b1;
        cyc(20);
        rst_n = 1'b1;
        cyc(40);
        check("t6_rel_rda", rda, 0);
        check("t6_rel_data", rx_data, 8'h00);
        check("t6_rel_ferr", framing_err, 0);
        ena_div = 4;
        cyc(8);
        send_frame(8'hC3, 64);
        cyc(8);
        check("t6_data", rx_data, 8'hC3);
        check("t6_rda", rda, 1);
        check("t6_ferr", framing_err, 0);
        check("t6_ovr", overrun, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
